// File: rtl/boot_mem_arbiter.sv
// Round-robin arbiter sharing one L2 data port between the SPI and JTAG boot loaders.
// One outstanding transaction; a response timeout returns ERR_DATA with an err pulse.
module boot_mem_arbiter #(
  parameter int          ADDR_WIDTH = 32,
  parameter int          TIMEOUT    = 255,
  parameter logic [31:0] ERR_DATA   = 32'hBADA_CCE5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req_i,
  input  logic [1:0]              we_i,
  input  logic [7:0]              be_i,
  input  logic [2*ADDR_WIDTH-1:0] addr_i,
  input  logic [63:0]             wdata_i,
  output logic [1:0]              gnt_o,
  output logic [1:0]              rvalid_o,
  output logic [31:0]             rdata_o,
  output logic                    err_o,
  output logic                    busy_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [3:0]              mem_be_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [31:0]             mem_wdata_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [31:0]             mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic        sel_q;
  logic        last_q;
  logic [15:0] cnt_q;

  logic sel_next;
  logic in_addr;
  logic in_resp;
  logic timeout_hit;
  logic resp_fire;

  // On contention, the requester not served last wins.
  assign sel_next    = (req_i[0] & req_i[1]) ? ~last_q : req_i[1];
  assign in_addr     = (state == ADDR);
  assign in_resp     = (state == RESP);
  assign timeout_hit = in_resp & (cnt_q == CNT_LAST);
  assign resp_fire   = in_resp & (mem_rvalid_i | timeout_hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      sel_q  <= 1'b0;
      last_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_i) begin
            sel_q  <= sel_next;
            last_q <= sel_next;
            state  <= ADDR;
          end
        end
        ADDR: begin
          if (mem_gnt_i) begin
            cnt_q <= '0;
            state <= RESP;
          end
        end
        RESP: begin
          if (mem_rvalid_i || timeout_hit) begin
            state <= IDLE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory-side request fields are forced to zero outside ADDR so the port is quiet when idle.
  assign mem_req_o   = in_addr;
  assign mem_we_o    = in_addr & (sel_q ? we_i[1] : we_i[0]);
  assign mem_be_o    = in_addr ? (sel_q ? be_i[7:4] : be_i[3:0]) : 4'h0;
  assign mem_addr_o  = in_addr ? (sel_q ? addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                        : addr_i[ADDR_WIDTH-1:0]) : '0;
  assign mem_wdata_o = in_addr ? (sel_q ? wdata_i[63:32] : wdata_i[31:0]) : 32'h0;

  assign gnt_o    = {in_addr & mem_gnt_i & sel_q, in_addr & mem_gnt_i & ~sel_q};
  assign rvalid_o = {resp_fire & sel_q, resp_fire & ~sel_q};
  // A real response arriving on the timeout cycle takes priority over the error.
  assign rdata_o  = !resp_fire   ? 32'h0 :
                    mem_rvalid_i ? mem_rdata_i : ERR_DATA;
  assign err_o    = timeout_hit & ~mem_rvalid_i;
  assign busy_o   = (state != IDLE);

  a_req_held: assert property (@(posedge clk) disable iff (rst)
    (state == ADDR) |-> req_i[sel_q]);

endmodule

// File: tb/tb_boot_mem_arbiter.sv
// Directed bench for boot_mem_arbiter with TIMEOUT=8.
module tb_boot_mem_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_i;
  logic [1:0]  we_i;
  logic [7:0]  be_i;
  logic [63:0] addr_i;
  logic [63:0] wdata_i;
  logic [1:0]  gnt_o;
  logic [1:0]  rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        busy_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  int n_cmp = 0;
  int n_err = 0;

  boot_mem_arbiter #(
    .ADDR_WIDTH (32),
    .TIMEOUT    (8),
    .ERR_DATA   (32'hBADA_CCE5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req_i),
    .we_i         (we_i),
    .be_i         (be_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .gnt_o        (gnt_o),
    .rvalid_o     (rvalid_o),
    .rdata_o      (rdata_o),
    .err_o        (err_o),
    .busy_o       (busy_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    logic [1:0]  exp_gnt;
    logic [31:0] exp_addr;

    rst = 1'b1; req_i = 2'b00; we_i = 2'b00; be_i = 8'hFF;
    addr_i = 64'h0; wdata_i = 64'h0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    #2;
    chk("rst_busy", busy_o, 0);
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_gnt", gnt_o, 0);
    chk("rst_rvalid", rvalid_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);

    // Single read by requester 0
    tick(); rst = 1'b0;
    req_i = 2'b01; addr_i[31:0] = 32'h0000_0100;
    #1 chk("rd_idle_busy", busy_o, 0);
    tick(); #1;
    chk("rd_mem_req", mem_req_o, 1);
    chk("rd_mem_addr", mem_addr_o, 32'h0000_0100);
    chk("rd_mem_we", mem_we_o, 0);
    chk("rd_gnt_wait", gnt_o, 2'b00);
    mem_gnt_i = 1'b1;
    #1 chk("rd_gnt", gnt_o, 2'b01);
    tick(); mem_gnt_i = 1'b0; req_i = 2'b00;
    #1;
    chk("rd_gnt_once", gnt_o, 2'b00);
    chk("rd_resp_mem_req", mem_req_o, 0);
    chk("rd_resp_busy", busy_o, 1);
    chk("rd_resp_wait", rvalid_o, 2'b00);
    tick(); mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
    #1;
    chk("rd_rvalid", rvalid_o, 2'b01);
    chk("rd_rdata", rdata_o, 32'hDEAD_BEEF);
    chk("rd_err", err_o, 0);
    tick(); mem_rvalid_i = 1'b0;
    #1;
    chk("rd_done_busy", busy_o, 0);
    chk("rd_done_rdata", rdata_o, 0);

    // Contention right after reset: 0,1,0,1
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    req_i = 2'b11; addr_i = {32'h0000_2000, 32'h0000_1000};
    for (int i = 0; i < 4; i++) begin
      exp_gnt  = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_addr = (i % 2 == 0) ? 32'h0000_1000 : 32'h0000_2000;
      tick(); #1;
      chk("arb_addr", mem_addr_o, exp_addr);
      mem_gnt_i = 1'b1;
      #1 chk("arb_gnt", gnt_o, exp_gnt);
      tick(); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'(i);
      #1;
      chk("arb_gnt_once", gnt_o, 2'b00);
      chk("arb_rvalid", rvalid_o, exp_gnt);
      tick(); mem_rvalid_i = 1'b0;
    end
    req_i = 2'b00;
    #1 chk("arb_end_busy", busy_o, 0);

    // Write by requester 1
    tick();
    req_i = 2'b10; we_i = 2'b10; be_i = 8'h3F;
    wdata_i = {32'h1234_5678, 32'hFFFF_FFFF};
    tick(); #1;
    chk("wr_mem_we", mem_we_o, 1);
    chk("wr_mem_be", mem_be_o, 4'b0011);
    chk("wr_mem_wdata", mem_wdata_o, 32'h1234_5678);
    chk("wr_mem_addr", mem_addr_o, 32'h0000_2000);
    mem_gnt_i = 1'b1;
    #1 chk("wr_gnt", gnt_o, 2'b10);
    tick(); mem_gnt_i = 1'b0; req_i = 2'b00; we_i = 2'b00;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0;
    #1 chk("wr_rvalid", rvalid_o, 2'b10);
    tick(); mem_rvalid_i = 1'b0;

    // Timeout: no response ever arrives
    req_i = 2'b01; addr_i[31:0] = 32'h0000_0300; be_i = 8'hFF;
    tick(); mem_gnt_i = 1'b1;
    #1 chk("to_gnt", gnt_o, 2'b01);
    for (int k = 1; k < 8; k++) begin
      tick(); mem_gnt_i = 1'b0; req_i = 2'b00;
      #1;
      chk("to_wait_rvalid", rvalid_o, 2'b00);
      chk("to_wait_err", err_o, 0);
    end
    tick(); #1;
    chk("to_rvalid", rvalid_o, 2'b01);
    chk("to_rdata", rdata_o, 32'hBADA_CCE5);
    chk("to_err", err_o, 1);
    tick(); mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1111_1111;
    #1;
    chk("late_busy", busy_o, 0);
    chk("late_rvalid", rvalid_o, 2'b00);
    chk("late_rdata", rdata_o, 0);
    chk("late_err", err_o, 0);

    // Response arriving on the timeout cycle wins
    tick(); mem_rvalid_i = 1'b0;
    req_i = 2'b01; addr_i[31:0] = 32'h0000_0500;
    tick(); mem_gnt_i = 1'b1;
    for (int k = 1; k < 8; k++) begin
      tick(); mem_gnt_i = 1'b0; req_i = 2'b00;
    end
    tick(); mem_rvalid_i = 1'b1; mem_rdata_i = 32'hA5A5_A5A5;
    #1;
    chk("sim_rvalid", rvalid_o, 2'b01);
    chk("sim_rdata", rdata_o, 32'hA5A5_A5A5);
    chk("sim_err", err_o, 0);
    tick(); mem_rvalid_i = 1'b0;
    #1 chk("sim_idle", busy_o, 0);

    // Reset while waiting in RESP abandons the transaction
    req_i = 2'b01; addr_i[31:0] = 32'h0000_0600;
    tick(); mem_gnt_i = 1'b1;
    tick(); mem_gnt_i = 1'b0; req_i = 2'b00;
    #1 chk("rr_in_resp", busy_o, 1);
    tick(); rst = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0077;
    #1;
    chk("rr_busy", busy_o, 0);
    chk("rr_rvalid", rvalid_o, 2'b00);
    chk("rr_rdata", rdata_o, 0);
    chk("rr_mem_req", mem_req_o, 0);
    tick(); rst = 1'b0; mem_rvalid_i = 1'b0;
    req_i = 2'b01; addr_i[31:0] = 32'h0000_0700;
    tick(); #1;
    chk("rr_next_mem_req", mem_req_o, 1);
    chk("rr_next_addr", mem_addr_o, 32'h0000_0700);
    mem_gnt_i = 1'b1;
    #1 chk("rr_next_gnt", gnt_o, 2'b01);
    tick(); mem_gnt_i = 1'b0; req_i = 2'b00;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D;
    #1;
    chk("rr_next_rvalid", rvalid_o, 2'b01);
    chk("rr_next_rdata", rdata_o, 32'hCAFE_F00D);
    tick(); mem_rvalid_i = 1'b0;
    #1 chk("rr_next_idle", busy_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
